rx_fifo: RTL
============

# rx_fifo

Byte buffer sitting directly downstream of the UART receiver. It captures each single-cycle `rx_valid`/`data` strobe into a first-word-fall-through FIFO and presents the bytes to the host side on a valid/ready handshake. It reports fill level, full, empty and almost-full (for RTS-style flow control). Bytes lost to overflow are tracked with a sticky flag and a saturating drop counter.

## Interface
- `ADDR_W`, 4: pointer width; depth = 2**ADDR_W entries (16).
- `AFULL_LVL`, 12: `almost_full` asserts when level >= this value; legal range 1..2**ADDR_W.
- `clk`  in  1  clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  single-cycle byte strobe from receiver (`rx_valid`).
- `wr_data`  in  8  received byte, sampled when `wr_valid`=1.
- `rd_valid`  out  1  head entry available; equals !empty.
- `rd_data`  out  8  head entry; meaningful only while `rd_valid`=1.
- `rd_ready`  in  1  consumer accepts head; pop occurs when `rd_valid & rd_ready`.
- `level`  out  ADDR_W+1  current entry count, 0..2**ADDR_W.
- `full`  out  1  level == 2**ADDR_W.
- `empty`  out  1  level == 0.
- `almost_full`  out  1  level >= AFULL_LVL.
- `overflow`  out  1  sticky: at least one byte dropped since last clear.
- `drop_cnt`  out  8  number of dropped bytes, saturates at 255.
- `ovf_clr`  in  1  single-cycle clear of `overflow` and `drop_cnt`.

## Operation
- Storage: 2**ADDR_W x 8 register array; write pointer `wp` and read pointer `rp` of ADDR_W+1 bits each, with the extra MSB as wrap bit.
  - level = wp - rp (modulo 2**(ADDR_W+1)).
  - full when the MSBs differ and the low bits are equal; empty when wp == rp.
- push = `wr_valid & (!full | pop)`. A write to a full FIFO is accepted only when a pop occurs in the same cycle.
- pop = `rd_valid & rd_ready`.
- Pointers increment by 1 on push/pop respectively and wrap naturally at 2**(ADDR_W+1).
- Drop event = `wr_valid & full & !pop`. The byte is discarded and the array and pointers are unchanged.
  - Drop sets `overflow`.
  - Drop increments `drop_cnt`, holding at 255 once reached.
- `ovf_clr` clears `overflow` to 0 and `drop_cnt` to 0.
  - If `ovf_clr` and a drop event occur in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- `rd_data` is a combinational read of array[rp]. When empty it holds the stale entry, which has no meaning.
- No state machine; behaviour is fully determined by the pointers and the overflow logic.

## Timing
- Reset values: wp=rp=0, level=0, empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, drop_cnt=0. Array contents are not reset; `rd_data` is undefined until the first write.
- Write latency: `wr_valid` at edge N → entry visible at N+1 (`rd_valid`=1, `rd_data`=byte, level+1).
- Pop: `rd_ready`=1 with `rd_valid`=1 at edge N → next entry on `rd_data` at N+1, level-1.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Empty with `wr_valid` and `rd_ready` in the same cycle: no pop, write accepted, level becomes 1.
- Full with `wr_valid` and pop in the same cycle: both accepted, level stays 2**ADDR_W, `overflow` unchanged.
- All flags (`full`, `empty`, `almost_full`, `level`) are registered or derived from registered pointers. None has a combinational path from `wr_valid` or `rd_ready`.
- `rd_valid` has no combinational dependence on `rd_ready`.
- Asynchronous reset mid-operation flushes the FIFO immediately. Every output listed above takes its reset value without waiting for a clock.
- Producer rate is at most 1 byte per `clk`. The receiver spaces its strobes far further apart than that, but the block must tolerate back-to-back `wr_valid`.

## Structure
- No shared package is required. Pointer width and depth derive from `ADDR_W` locally.
- A package with a byte-width constant of 8 is acceptable if the team already keeps one for the UART.
- One natural sub-module: `rx_fifo_mem`, the register array with a synchronous write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr` → `rdata`). Pointers, flags and overflow logic stay in `rx_fifo`.

## Test plan
- Single byte: wr 0xA5, `rd_ready`=0 → next cycle rd_valid=1, rd_data=0xA5, level=1; pulse `rd_ready` → empty=1, level=0.
- Fill and order: 16 back-to-back writes 0x00..0x0F → full=1, almost_full=1 from the 12th entry onward; drain with `rd_ready`=1 → 0x00..0x0F in order, then empty=1.
- Overflow: full FIFO, 3 further writes 0xE0..0xE2 with `rd_ready`=0 → overflow=1, drop_cnt=3, contents still 0x00..0x0F; `ovf_clr` → overflow=0, drop_cnt=0.
- Simultaneous events:
  - Full FIFO, wr 0x55 with pop → level stays 16, overflow=0, 0x55 emerges last.
  - `ovf_clr` coincident with a drop → overflow=1, drop_cnt=1.
- Wrap and saturation:
  - Stream 100 bytes with random `rd_ready` → output order matches input across pointer wrap.
  - 300 drops → drop_cnt=255.
- Reset mid-operation: level=7, assert rstb=0 between clock edges → empty=1, rd_valid=0, level=0 immediately; after release, wr 0x3C reads back 0x3C.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// Shared constants for the UART receive path: byte width and the
// saturating drop counter used by rx_fifo.
package rx_fifo_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Register-array storage for rx_fifo: synchronous write port and
// asynchronous read port so the head entry falls through with no latency.
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are deliberately not reset; the pointers decide what is valid.
    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with level
// flags for RTS flow control and sticky overflow / saturating drop count.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_valid,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [BYTE_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              ovf_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] AFULL_THR = (ADDR_W + 1)'(AFULL_LVL);

    // Pointers carry one extra MSB as a wrap bit to tell full from empty.
    logic [ADDR_W:0] wp;
    logic [ADDR_W:0] rp;
    logic            push;
    logic            pop;
    logic            drop;

    assign level       = wp - rp;
    assign empty       = (wp == rp);
    assign full        = (wp[ADDR_W] != rp[ADDR_W]) &&
                         (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
    assign almost_full = (level >= AFULL_THR);
    assign rd_valid    = !empty;

    assign pop  = rd_valid & rd_ready;
    assign push = wr_valid & (!full | pop);
    assign drop = wr_valid & full & !pop;

    rx_fifo_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rp[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= ovf_clr ? CNT_W'(1) : sat_inc(drop_cnt);
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    level_bounded: assert property (@(posedge clk) disable iff (!rstb)
        level <= (ADDR_W + 1)'(DEPTH));

endmodule
